// File: rtl/alu_operand_stage_if.sv
// Handshake bundle for alu_operand_stage.
// Upstream channel: in_valid/in_ready plus decoded instruction fields and operand data.
// Downstream channel: out_valid/out_ready plus ALU operands, ALU select, rd and illegal flag.
// Modport slave is the stage itself; modport master is the surrounding pipeline.
interface alu_operand_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
);
    // Upstream
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [RD_W-1:0] rd;
    // Downstream
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      alu_sel;
    logic [RD_W-1:0] rd_out;
    logic            illegal;

    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc, rd,
        output out_ready,
        input  in_ready, out_valid, a, b, alu_sel, rd_out, illegal
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc, rd,
        input  out_ready,
        output in_ready, out_valid, a, b, alu_sel, rd_out, illegal
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered ALU issue stage.
// Decodes RV32I OP / OP-IMM / LUI / AUIPC into an ALU select and operands a/b, and
// buffers the result in a 2-entry skid (main + skid) so in_ready can be registered
// while still sustaining one instruction per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   flush  synchronous; drops main and skid entries
//   bus    alu_operand_stage_if.slave (upstream + downstream handshake channels)
module alu_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RD_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    alu_operand_stage_if.slave    bus
);
    // ALU select encoding shared with the ALU.
    localparam logic [3:0] ALU_NOP     = 4'd0;
    localparam logic [3:0] ALU_ADD     = 4'd1;
    localparam logic [3:0] ALU_SUB     = 4'd2;
    localparam logic [3:0] ALU_SLL     = 4'd3;
    localparam logic [3:0] ALU_SLT     = 4'd4;
    localparam logic [3:0] ALU_SLTU    = 4'd5;
    localparam logic [3:0] ALU_XOR     = 4'd6;
    localparam logic [3:0] ALU_SRL     = 4'd7;
    localparam logic [3:0] ALU_SRA     = 4'd8;
    localparam logic [3:0] ALU_OR      = 4'd9;
    localparam logic [3:0] ALU_AND     = 4'd10;
    localparam logic [3:0] ALU_INVALID = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct3 -> ALU select; alt picks SUB for 000 and SRA for 101.
    function automatic logic [3:0] f3_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_sel = ALU_SLL;
            3'b010:  f3_sel = ALU_SLT;
            3'b011:  f3_sel = ALU_SLTU;
            3'b100:  f3_sel = ALU_XOR;
            3'b101:  f3_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_sel = ALU_OR;
            default: f3_sel = ALU_AND;
        endcase
    endfunction

    logic [XLEN-1:0] dec_a, dec_b;
    logic [3:0]      dec_sel;
    logic            dec_illegal;
    logic            is_shift;

    always_comb begin
        dec_a       = '0;
        dec_b       = '0;
        dec_sel     = ALU_INVALID;
        dec_illegal = 1'b1;
        is_shift    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
        case (bus.opcode)
            OPC_OP: begin
                // funct7[5] is only meaningful for ADD/SUB and SRL/SRA.
                if (!(bus.funct7_5 && bus.funct3 != 3'b000 && bus.funct3 != 3'b101)) begin
                    dec_a       = bus.rs1_data;
                    dec_b       = bus.rs2_data;
                    dec_sel     = f3_sel(bus.funct3, bus.funct7_5);
                    dec_illegal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                if (!(bus.funct3 == 3'b001 && bus.imm[10])) begin
                    dec_a       = bus.rs1_data;
                    dec_b       = is_shift ? {{(XLEN-5){1'b0}}, bus.imm[4:0]} : bus.imm;
                    // No SUBI: only the shift-right form honours the alt bit.
                    dec_sel     = f3_sel(bus.funct3, (bus.funct3 == 3'b101) && bus.imm[10]);
                    dec_illegal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec_b       = bus.imm;
                dec_sel     = ALU_ADD;
                dec_illegal = 1'b0;
            end
            OPC_AUIPC: begin
                dec_a       = bus.pc;
                dec_b       = bus.imm;
                dec_sel     = ALU_ADD;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    logic            main_valid_q, skid_valid_q;
    logic [XLEN-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
    logic [3:0]      main_sel_q, skid_sel_q;
    logic [RD_W-1:0] main_rd_q, skid_rd_q;
    logic            main_ill_q, skid_ill_q;
    logic            pop, push;

    assign pop  = main_valid_q && bus.out_ready;
    assign push = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_a_q     <= '0;
            main_b_q     <= '0;
            main_sel_q   <= ALU_NOP;
            main_rd_q    <= '0;
            main_ill_q   <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_sel_q   <= ALU_NOP;
            skid_rd_q    <= '0;
            skid_ill_q   <= 1'b0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so no push can coincide with the refill.
            if (pop) begin
                main_a_q     <= skid_a_q;
                main_b_q     <= skid_b_q;
                main_sel_q   <= skid_sel_q;
                main_rd_q    <= skid_rd_q;
                main_ill_q   <= skid_ill_q;
                skid_valid_q <= 1'b0;
            end
        end else if (!main_valid_q || pop) begin
            main_valid_q <= push;
            if (push) begin
                main_a_q   <= dec_a;
                main_b_q   <= dec_b;
                main_sel_q <= dec_sel;
                main_rd_q  <= bus.rd;
                main_ill_q <= dec_illegal;
            end
        end else if (push) begin
            skid_valid_q <= 1'b1;
            skid_a_q     <= dec_a;
            skid_b_q     <= dec_b;
            skid_sel_q   <= dec_sel;
            skid_rd_q    <= bus.rd;
            skid_ill_q   <= dec_illegal;
        end
    end

    // skid_valid_q is a flop, so in_ready is registered.
    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.a         = main_a_q;
    assign bus.b         = main_b_q;
    assign bus.alu_sel   = main_sel_q;
    assign bus.rd_out    = main_rd_q;
    assign bus.illegal   = main_ill_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
    localparam logic [3:0] S_NOP = 4'd0,  S_ADD = 4'd1,  S_SUB = 4'd2,  S_SLL = 4'd3;
    localparam logic [3:0] S_XOR = 4'd6,  S_SRA = 4'd8,  S_AND = 4'd10, S_INV = 4'd15;
    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage_if #(.XLEN(32), .RD_W(5)) bus ();

    alu_operand_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] im, input logic [31:0] p, input logic [4:0] rdi);
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7_5 = f75;
        bus.rs1_data = rs1;
        bus.rs2_data = rs2;
        bus.imm      = im;
        bus.pc       = p;
        bus.rd       = rdi;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [3:0] sel,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [4:0] erd, input logic ill);
        check({tag, ".valid"}, {31'b0, bus.out_valid}, {31'b0, v});
        check({tag, ".sel"}, {28'b0, bus.alu_sel}, {28'b0, sel});
        check({tag, ".a"}, bus.a, ea);
        check({tag, ".b"}, bus.b, eb);
        check({tag, ".rd"}, {27'b0, bus.rd_out}, {27'b0, erd});
        check({tag, ".ill"}, {31'b0, bus.illegal}, {31'b0, ill});
    endtask

    task automatic expect_ready(input string tag, input logic r);
        check(tag, {31'b0, bus.in_ready}, {31'b0, r});
    endtask

    initial begin
        bus.out_ready = 1'b1;
        drive(OP, 3'b000, 1'b0, 32'h11, 32'h22, 32'h0, 32'h0, 5'd9);

        // Reset held 2 cycles with in_valid high
        reset = 1'b0;
        tick();
        tick();
        expect_out("reset", 1'b0, S_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        expect_ready("reset.rdy", 1'b1);

        // Back-to-back decode stream, downstream always ready
        reset = 1'b1;
        drive(OP, 3'b000, 1'b1, 32'h100, 32'h7F, 32'h0, 32'h0, 5'd5);
        tick();
        expect_out("sub", 1'b1, S_SUB, 32'h100, 32'h7F, 5'd5, 1'b0);
        drive(OPI, 3'b101, 1'b0, 32'h8000_0010, 32'hFFFF, 32'h402, 32'h0, 5'd6);
        tick();
        expect_out("srai", 1'b1, S_SRA, 32'h8000_0010, 32'h2, 5'd6, 1'b0);
        drive(AUIPC, 3'b000, 1'b0, 32'h55, 32'h66, 32'h5000, 32'h1000, 5'd7);
        tick();
        expect_out("auipc", 1'b1, S_ADD, 32'h1000, 32'h5000, 5'd7, 1'b0);
        drive(LUI, 3'b000, 1'b0, 32'hDEAD, 32'h66, 32'h1234_5000, 32'h1000, 5'd8);
        tick();
        expect_out("lui", 1'b1, S_ADD, 32'h0, 32'h1234_5000, 5'd8, 1'b0);
        // ADDI with f7_5 set must still be ADD
        drive(OPI, 3'b000, 1'b1, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd10);
        tick();
        expect_out("addi", 1'b1, S_ADD, 32'h10, 32'hFFFF_FFFF, 5'd10, 1'b0);
        drive(OPI, 3'b001, 1'b0, 32'h3, 32'h0, 32'h0000_0025, 32'h0, 5'd11);
        tick();
        expect_out("slli", 1'b1, S_SLL, 32'h3, 32'h5, 5'd11, 1'b0);
        drive(OPI, 3'b001, 1'b0, 32'h3, 32'h0, 32'h401, 32'h0, 5'd12);
        tick();
        expect_out("slli_ill", 1'b1, S_INV, 32'h0, 32'h0, 5'd12, 1'b1);
        drive(OP, 3'b100, 1'b1, 32'h3, 32'h4, 32'h0, 32'h0, 5'd13);
        tick();
        expect_out("xor_f7", 1'b1, S_INV, 32'h0, 32'h0, 5'd13, 1'b1);
        drive(OP, 3'b100, 1'b0, 32'h3, 32'h4, 32'h0, 32'h0, 5'd14);
        tick();
        expect_out("xor", 1'b1, S_XOR, 32'h3, 32'h4, 5'd14, 1'b0);
        drive(7'h03, 3'b010, 1'b0, 32'h3, 32'h4, 32'h8, 32'h40, 5'd15);
        tick();
        expect_out("load_ill", 1'b1, S_INV, 32'h0, 32'h0, 5'd15, 1'b1);
        expect_ready("stream.rdy", 1'b1);
        bus.in_valid = 1'b0;
        tick();
        check("drain.valid", {31'b0, bus.out_valid}, 32'h0);

        // Stall: I0, I1, I2 with downstream blocked
        bus.out_ready = 1'b0;
        drive(OP, 3'b111, 1'b0, 32'h1, 32'hF0, 32'h0, 32'h0, 5'd1);
        tick();
        expect_out("stall.i0", 1'b1, S_AND, 32'h1, 32'hF0, 5'd1, 1'b0);
        expect_ready("stall.rdy0", 1'b1);
        drive(OP, 3'b000, 1'b0, 32'h3, 32'h4, 32'h0, 32'h0, 5'd2);
        tick();
        expect_out("stall.hold1", 1'b1, S_AND, 32'h1, 32'hF0, 5'd1, 1'b0);
        expect_ready("stall.rdy1", 1'b0);
        drive(OP, 3'b000, 1'b1, 32'h5, 32'h1, 32'h0, 32'h0, 5'd3);
        tick();
        expect_out("stall.hold2", 1'b1, S_AND, 32'h1, 32'hF0, 5'd1, 1'b0);
        expect_ready("stall.rdy2", 1'b0);
        bus.out_ready = 1'b1;
        tick();
        expect_out("stall.i1", 1'b1, S_ADD, 32'h3, 32'h4, 5'd2, 1'b0);
        expect_ready("stall.rdy3", 1'b1);
        tick();
        bus.in_valid = 1'b0;
        expect_out("stall.i2", 1'b1, S_SUB, 32'h5, 32'h1, 5'd3, 1'b0);
        tick();
        check("stall.empty", {31'b0, bus.out_valid}, 32'h0);

        // Flush with both entries full and a push pending
        bus.out_ready = 1'b0;
        drive(OP, 3'b000, 1'b0, 32'h9, 32'h1, 32'h0, 32'h0, 5'd20);
        tick();
        drive(OP, 3'b000, 1'b0, 32'hA, 32'h1, 32'h0, 32'h0, 5'd21);
        tick();
        expect_ready("flush.full", 1'b0);
        drive(OP, 3'b000, 1'b0, 32'hB, 32'h1, 32'h0, 32'h0, 5'd22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush.valid", {31'b0, bus.out_valid}, 32'h0);
        expect_ready("flush.rdy", 1'b1);
        bus.out_ready = 1'b1;
        tick();
        check("flush.resid", {31'b0, bus.out_valid}, 32'h0);

        // Mid-stream reset returns outputs to reset values
        drive(OP, 3'b110, 1'b0, 32'h77, 32'h88, 32'h0, 32'h0, 5'd30);
        bus.out_ready = 1'b0;
        tick();
        check("mid.pre", {31'b0, bus.out_valid}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        expect_out("mid.reset", 1'b0, S_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        expect_ready("mid.rdy", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
